// File: rtl/next_kms_scheduler_if.sv
// Signal bundle between the NeXT keyboard/mouse link scheduler and its environment
// (host control, serial transmitter, serial receiver).
interface next_kms_scheduler_if;
  logic        enable;
  logic        reset_req;
  logic        reset_ack;
  logic        led_req;
  logic [1:0]  led_val;
  logic        led_ack;
  logic        tx_start;
  logic [7:0]  tx_cmd;
  logic        tx_busy;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_src;
  logic [7:0]  timeout_cnt;
  logic [2:0]  state;

  // master: the scheduler, which owns the serial link
  modport master (
    input  enable, reset_req, led_req, led_val, tx_busy, rx_valid, rx_data,
    output reset_ack, led_ack, tx_start, tx_cmd, rsp_valid, rsp_data, rsp_src, timeout_cnt,
           state
  );

  modport slave (
    output enable, reset_req, led_req, led_val, tx_busy, rx_valid, rx_data,
    input  reset_ack, led_ack, tx_start, tx_cmd, rsp_valid, rsp_data, rsp_src, timeout_cnt,
           state
  );
endinterface

// File: rtl/next_kms_scheduler.sv
// Time-shares the NeXT keyboard/mouse serial link between reset, LED and periodic polls.
// Define NEXT_KMS_MOUSE_EN to alternate keyboard and mouse polls; otherwise only the keyboard.
module next_kms_scheduler #(
  parameter int unsigned POLL_CYCLES    = 13500,
  parameter int unsigned TIMEOUT_CYCLES = 2700
) (
  input logic                  clk,
  input logic                  rst,
  next_kms_scheduler_if.master bus
);

  localparam int unsigned PollW = $clog2(POLL_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PollW-1:0] PollReload = PollW'(POLL_CYCLES - 1);
  localparam logic [ToW-1:0]   ToReload   = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StTxAccept = 3'd2,
    StTxDrain  = 3'd3,
    StWaitRsp  = 3'd4
  } state_e;

  typedef enum logic [1:0] {CmdReset, CmdLed, CmdPoll} kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [7:0]       tx_cmd_q, tx_cmd_d;
  logic [PollW-1:0] timer_q, timer_d;
  logic             pending_q, pending_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic             reset_ack_q, reset_ack_d;
  logic             led_ack_q, led_ack_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             rsp_src_q, rsp_src_d;
  logic             grant_poll;
  logic             mouse_turn;

`ifdef NEXT_KMS_MOUSE_EN
  logic target_q;

  // Toggle after every poll, whether answered or timed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= 1'b0;
    end else if (state_q == StWaitRsp && (bus.rx_valid || to_q == '0)) begin
      target_q <= ~target_q;
    end
  end
  assign mouse_turn = target_q;
`else
  assign mouse_turn = 1'b0;
`endif

  // Poll timer; a tick while a poll is already pending is simply lost.
  always_comb begin
    timer_d   = timer_q;
    pending_d = pending_q;
    if (!bus.enable) begin
      timer_d   = PollReload;
      pending_d = 1'b0;
    end else begin
      timer_d = (timer_q == '0) ? PollReload : timer_q - 1'b1;
      if (grant_poll) begin
        pending_d = 1'b0;
      end else if (timer_q == '0) begin
        pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    tx_cmd_d    = tx_cmd_q;
    to_d        = to_q;
    to_cnt_d    = to_cnt_q;
    reset_ack_d = 1'b0;
    led_ack_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_src_d   = rsp_src_q;
    grant_poll  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A request whose ack is on the wire this cycle is already served.
        if (bus.enable) begin
          if (bus.reset_req && !reset_ack_q) begin
            state_d  = StIssue;
            kind_d   = CmdReset;
            tx_cmd_d = 8'hEF;
          end else if (bus.led_req && !led_ack_q) begin
            state_d  = StIssue;
            kind_d   = CmdLed;
            tx_cmd_d = {6'b001000, bus.led_val};
          end else if (pending_q) begin
            state_d    = StIssue;
            kind_d     = CmdPoll;
            tx_cmd_d   = {7'b0001000, mouse_turn};
            grant_poll = 1'b1;
          end
        end
      end
      StIssue: state_d = StTxAccept;
      StTxAccept: begin
        if (bus.tx_busy) state_d = StTxDrain;
      end
      StTxDrain: begin
        if (!bus.tx_busy) begin
          if (kind_q == CmdPoll) begin
            state_d = StWaitRsp;
            to_d    = ToReload;
          end else begin
            state_d     = StIdle;
            reset_ack_d = (kind_q == CmdReset);
            led_ack_d   = (kind_q == CmdLed);
          end
        end
      end
      StWaitRsp: begin
        if (bus.rx_valid) begin
          state_d = StIdle;
          if (bus.rx_data != 16'h0000) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.rx_data;
            rsp_src_d   = mouse_turn;
          end
        end else if (to_q == '0) begin
          state_d = StIdle;
          if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
        end else begin
          to_d = to_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      kind_q      <= CmdReset;
      tx_cmd_q    <= 8'h00;
      timer_q     <= PollReload;
      pending_q   <= 1'b0;
      to_q        <= '0;
      to_cnt_q    <= 8'h00;
      reset_ack_q <= 1'b0;
      led_ack_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      tx_cmd_q    <= tx_cmd_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      to_q        <= to_d;
      to_cnt_q    <= to_cnt_d;
      reset_ack_q <= reset_ack_d;
      led_ack_q   <= led_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_src_q   <= rsp_src_d;
    end
  end

  assign bus.tx_start    = (state_q == StIssue);
  assign bus.tx_cmd      = tx_cmd_q;
  assign bus.reset_ack   = reset_ack_q;
  assign bus.led_ack     = led_ack_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_src     = rsp_src_q;
  assign bus.timeout_cnt = to_cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_next_kms_scheduler.sv
// Bench for next_kms_scheduler: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_next_kms_scheduler;
  localparam int POLL = 100;
  localparam int TMO  = 10;
  localparam int P_IDLE = 0, P_STROBE = 1, P_AWAIT = 2, P_DRAIN = 3, P_WAIT = 4;
  localparam int K_RESET = 0, K_LED = 1, K_POLL = 2;
`ifdef NEXT_KMS_MOUSE_EN
  localparam logic [7:0] ALT_POLL = 8'h11;
`else
  localparam logic [7:0] ALT_POLL = 8'h10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  next_kms_scheduler_if dif();

  next_kms_scheduler #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int         m_run, m_phase, m_kind, m_deadline, m_cyc;
  bit         m_pending, m_mouse;
  logic [7:0] e_cmd, e_tocnt;
  bit         e_rack, e_lack, e_rv, e_src;
  logic [15:0] e_rdata;

  task automatic m_reset();
    m_run = 0; m_phase = P_IDLE; m_kind = K_RESET; m_deadline = 0; m_cyc = 0;
    m_pending = 0; m_mouse = 0;
    e_cmd = 8'h00; e_tocnt = 8'h00; e_rack = 0; e_lack = 0; e_rv = 0; e_src = 0;
    e_rdata = 16'h0000;
  endtask

  task automatic m_step();
    bit tick, took_poll, fin_poll, prev_rack, prev_lack;
    tick      = dif.enable && ((m_run % POLL) == POLL - 1);
    took_poll = 0;
    fin_poll  = 0;
    prev_rack = e_rack;
    prev_lack = e_lack;
    e_rack = 0; e_lack = 0; e_rv = 0;
    case (m_phase)
      P_IDLE: if (dif.enable) begin
        if (dif.reset_req && !prev_rack) begin
          m_kind = K_RESET; e_cmd = 8'hEF; m_phase = P_STROBE;
        end else if (dif.led_req && !prev_lack) begin
          m_kind = K_LED; e_cmd = 8'h20 + 8'(dif.led_val); m_phase = P_STROBE;
        end else if (m_pending) begin
          m_kind = K_POLL; e_cmd = m_mouse ? 8'h11 : 8'h10; m_phase = P_STROBE; took_poll = 1;
        end
      end
      P_STROBE: m_phase = P_AWAIT;
      P_AWAIT:  if (dif.tx_busy) m_phase = P_DRAIN;
      P_DRAIN:  if (!dif.tx_busy) begin
        if (m_kind == K_POLL) begin
          m_phase = P_WAIT; m_deadline = m_cyc + TMO;
        end else begin
          e_rack = (m_kind == K_RESET); e_lack = (m_kind == K_LED); m_phase = P_IDLE;
        end
      end
      P_WAIT: begin
        if (dif.rx_valid) begin
          if (dif.rx_data != 16'h0000) begin e_rv = 1; e_rdata = dif.rx_data; e_src = m_mouse; end
          fin_poll = 1;
        end else if (m_cyc == m_deadline) begin
          if (e_tocnt < 8'd255) e_tocnt = e_tocnt + 8'd1;
          fin_poll = 1;
        end
      end
      default: m_phase = P_IDLE;
    endcase
    if (fin_poll) begin
      m_phase = P_IDLE;
`ifdef NEXT_KMS_MOUSE_EN
      m_mouse = !m_mouse;
`endif
    end
    if (!dif.enable) m_pending = 0;
    else if (took_poll) m_pending = 0;
    else if (tick) m_pending = 1;
    m_run = dif.enable ? m_run + 1 : 0;
    m_cyc++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Single compare process: every output, every cycle, mid-cycle.
  initial forever begin
    @(negedge clk);
    check("state", dif.state, m_phase);
    check("tx_start", dif.tx_start, m_phase == P_STROBE);
    check("tx_cmd", dif.tx_cmd, e_cmd);
    check("reset_ack", dif.reset_ack, e_rack);
    check("led_ack", dif.led_ack, e_lack);
    check("rsp_valid", dif.rsp_valid, e_rv);
    check("rsp_data", dif.rsp_data, e_rdata);
    check("rsp_src", dif.rsp_src, e_src);
    check("timeout_cnt", dif.timeout_cnt, e_tocnt);
  end

  // ---------------- environment: host, transmitter, receiver ----------------
  int cyc = 0;
  int tx_wait = 0, tx_left = 0, tx_wait_max = 0, tx_len_max = 1;
  int rsp_wait = -1, rsp_min = 0, rsp_max = 0, rx_fired_cyc = -1;
  bit armed = 0, rsp_never = 0, rsp_fixed = 1, rand_mode = 0;
  logic [15:0] rsp_fixed_data = 16'h0042;

  task automatic env();
    if (dif.tx_start) begin
      tx_wait = $urandom_range(0, tx_wait_max);
      tx_left = $urandom_range(1, tx_len_max);
      dif.tx_busy = 1'b0;
    end else if (tx_wait > 0) begin
      dif.tx_busy = 1'b0; tx_wait--;
    end else if (tx_left > 0) begin
      dif.tx_busy = 1'b1; tx_left--;
    end else begin
      dif.tx_busy = 1'b0;
    end
    dif.rx_valid = 1'b0;
    if (dif.state == 3'd4) begin
      if (!armed) begin
        armed = 1;
        rsp_wait = rsp_never ? (1 << 20) : $urandom_range(rsp_min, rsp_max);
      end
      if (rsp_wait == 0) begin
        dif.rx_valid = 1'b1;
        dif.rx_data = rsp_fixed ? rsp_fixed_data
                    : (($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
        rx_fired_cyc = cyc;
      end
      rsp_wait--;
    end else begin
      armed = 0;
      if (rand_mode && $urandom_range(0, 99) < 3) begin
        dif.rx_valid = 1'b1; dif.rx_data = 16'($urandom);
      end
    end
    if (dif.reset_ack) dif.reset_req = 1'b0;
    if (dif.led_ack) dif.led_req = 1'b0;
    if (rand_mode) begin
      if (!dif.reset_req && !dif.reset_ack && $urandom_range(0, 999) < 3) dif.reset_req = 1'b1;
      if (!dif.led_req && !dif.led_ack && $urandom_range(0, 999) < 5) dif.led_req = 1'b1;
      dif.led_val = 2'($urandom);
      if (dif.enable && $urandom_range(0, 999) < 3) dif.enable = 1'b0;
      else if (!dif.enable && $urandom_range(0, 99) < 5) dif.enable = 1'b1;
      rst = ($urandom_range(0, 2999) == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    env();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (dif.state !== s && n < budget) begin step(); n++; end
    check(name, dif.state, s);
  endtask

  task automatic wait_start(input int budget, input string name);
    int n = 0;
    while (dif.tx_start !== 1'b1 && n < budget) begin step(); n++; end
    check(name, dif.tx_start, 1'b1);
  endtask

  // ---------------- directed scenarios, then random traffic ----------------
  initial begin
    int t[4];
    logic [7:0] c[4];
    int n, k, cnt, rxc, prev;
    logic [7:0] p0, p1;
    int ack_cyc, s1_cyc;
    bit got_rsp;

    dif.enable = 0; dif.reset_req = 0; dif.led_req = 0; dif.led_val = 0;
    dif.tx_busy = 0; dif.rx_valid = 0; dif.rx_data = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dif.state, 3'd0);
    check("rst_tx_start", dif.tx_start, 1'b0);
    check("rst_tx_cmd", dif.tx_cmd, 8'h00);
    check("rst_timeout_cnt", dif.timeout_cnt, 8'h00);
    check("rst_outputs", {dif.reset_ack, dif.led_ack, dif.rsp_valid, dif.rsp_src}, 4'b0000);
    check("rst_rsp_data", dif.rsp_data, 16'h0000);
    rst = 1'b0;
    dif.enable = 1'b1;

    // Periodic polling with prompt 0x0042 responses.
    n = 0; k = 0; got_rsp = 0;
    while (n < 4 && k < 600) begin
      step(); k++;
      if (dif.tx_start) begin t[n] = cyc; c[n] = dif.tx_cmd; n++; end
      if (dif.rsp_valid && !got_rsp) begin
        got_rsp = 1;
        check("rsp_latency", cyc - rx_fired_cyc, 1);
        check("rsp_data_0042", dif.rsp_data, 16'h0042);
        check("rsp_src_kbd", dif.rsp_src, 1'b0);
      end
    end
    check("poll_count", n, 4);
    check("rsp_seen", got_rsp, 1'b1);
    if (n == 4) begin
      for (int i = 1; i < 4; i++) check("poll_period", t[i] - t[i-1], POLL);
      check("poll_cmd0", c[0], 8'h10);
      check("poll_cmd1", c[1], ALT_POLL);
      check("poll_cmd2", c[2], 8'h10);
      check("poll_cmd3", c[3], ALT_POLL);
    end

    // Zero response word is filtered.
    rsp_fixed_data = 16'h0000;
    wait_start(200, "zero_poll_start");
    cnt = 0; rxc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dif.rsp_valid) cnt++;
      if (dif.rx_valid) rxc++;
    end
    check("zero_filtered", cnt, 0);
    check("zero_rx_seen", rxc, 1);

    // Reset and LED requested together.
    wait_state(3'd0, 50, "prio_idle");
    dif.led_val = 2'b10; dif.reset_req = 1'b1; dif.led_req = 1'b1;
    n = 0; k = 0; ack_cyc = -1; s1_cyc = -1; p0 = 8'h00; p1 = 8'h00;
    while ((dif.reset_req || dif.led_req) && k < 300) begin
      step(); k++;
      if (dif.tx_start && n == 0) begin p0 = dif.tx_cmd; n++; end
      else if (dif.tx_start && n == 1) begin p1 = dif.tx_cmd; s1_cyc = cyc; n++; end
      if (dif.reset_ack) ack_cyc = cyc;
    end
    check("prio_first_cmd", p0, 8'hEF);
    check("prio_second_cmd", p1, 8'h22);
    check("prio_ack_order", (ack_cyc >= 0) && (ack_cyc < s1_cyc), 1'b1);
    check("prio_both_acked", {dif.reset_req, dif.led_req}, 2'b00);

    // Unanswered poll times out after TMO cycles in WAIT_RSP.
    rsp_never = 1; rsp_fixed_data = 16'h0055;
    wait_state(3'd4, 300, "tmo_enter_wait");
    n = 1;
    while (dif.state == 3'd4 && n < 50) begin step(); if (dif.state == 3'd4) n++; end
    check("tmo_wait_cycles", n, TMO);
    check("tmo_count_1", dif.timeout_cnt, 8'd1);

    // Response on the final timeout cycle wins.
    rsp_never = 0; rsp_min = TMO - 1; rsp_max = TMO - 1;
    k = 0;
    while (!dif.rsp_valid && k < 300) begin step(); k++; end
    check("race_rsp_valid", dif.rsp_valid, 1'b1);
    check("race_rsp_data", dif.rsp_data, 16'h0055);
    check("race_timeout_cnt", dif.timeout_cnt, 8'd1);

    // 300 more timeouts saturate the counter.
    rsp_never = 1; n = 0; k = 0; prev = dif.state;
    while (n < 300 && k < 40000) begin
      step(); k++;
      if (dif.state == 3'd4 && prev != 4) n++;
      prev = dif.state;
    end
    wait_state(3'd0, 50, "sat_idle");
    check("sat_timeout_cnt", dif.timeout_cnt, 8'd255);

    // Enable dropped mid-drain: transaction finishes, nothing new starts.
    rsp_never = 0; rsp_min = 1; rsp_max = 1; tx_len_max = 4;
    wait_state(3'd3, 300, "en_reach_drain");
    dif.enable = 1'b0;
    wait_state(3'd0, 50, "en_completes");
    cnt = 0;
    for (int i = 0; i < 300; i++) begin step(); if (dif.tx_start) cnt++; end
    check("en_no_start", cnt, 0);
    dif.enable = 1'b1;

    // Random traffic.
    rand_mode = 1; rsp_fixed = 0; tx_wait_max = 3; tx_len_max = 4; rsp_min = 0; rsp_max = 12;
    repeat (15000) step();
    rand_mode = 0; rst = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/next_kms_scheduler.md
# next_kms_scheduler

Transaction scheduler for the NeXT keyboard/mouse serial link, sitting between the host-side control logic (LED and reset requests, enable) and the serial transmitter/receiver pair driving `to_kb`/`from_kb`. It time-shares the single link between four requesters: keyboard reset, LED update, periodic keyboard poll and periodic mouse poll. It issues one command at a time, waits for the transmitter to drain, and collects the poll response or times out. Filtered key and mouse events are delivered as one-cycle pulses.

## Interface
Parameters:
- `POLL_CYCLES`, default 13500: clocks between poll ticks (500 µs at 27 MHz).
- `TIMEOUT_CYCLES`, default 2700: clocks to wait for a poll response (100 µs).

Ports (clock and reset first):
- `clk` in 1: 27 MHz system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level; when low, no new transaction starts.
- `reset_req` in 1: level request for a keyboard reset command; hold until `reset_ack`.
- `reset_ack` out 1: one-cycle pulse when the reset command has drained.
- `led_req` in 1: level request for an LED update; hold until `led_ack`.
- `led_val` in 2: LED bits, sampled on the cycle the LED command enters ISSUE.
- `led_ack` out 1: one-cycle pulse when the LED command has drained.
- `tx_start` out 1: command strobe to the transmitter.
- `tx_cmd` out 8: command byte; held stable from ISSUE until the next ISSUE.
- `tx_busy` in 1: transmitter busy.
- `rx_valid` in 1: one-cycle pulse, response word available.
- `rx_data` in 16: response word.
- `rsp_valid` out 1: one-cycle pulse, event delivered.
- `rsp_data` out 16: event word.
- `rsp_src` out 1: event source; 0 = keyboard, 1 = mouse.
- `timeout_cnt` out 8: saturating count of poll timeouts.
- `state` out 3: current FSM state encoding, for LEDs/debug.

## Operation
- **Command bytes**
  - KB_RESET = 8'hEF
  - LED_SET = {6'b001000, led_val}
  - KBD_POLL = 8'h10
  - MOUSE_POLL = 8'h11
- **Poll timer**
  - Down-counter reloads to `POLL_CYCLES-1`.
  - On reaching 0 it sets `poll_pending`.
  - A tick while `poll_pending` is already set is dropped; there is no queueing.
  - While `enable` is low, the timer is held at reload and `poll_pending` is cleared.
- **Arbitration** (in IDLE, only when `enable` is high), fixed priority: `reset_req` > `led_req` > `poll_pending`.
  - A granted poll clears `poll_pending`.
  - The poll target alternates keyboard/mouse, starting with keyboard after reset.
  - The target toggles after every poll, whether it completes or times out.
- **FSM states** (`state` encoding in brackets):
  - IDLE [0]: arbitrate; move to ISSUE on any grant.
  - ISSUE [1]: `tx_start`=1 and `tx_cmd` loaded; always exits to TX_ACCEPT next cycle.
  - TX_ACCEPT [2]: wait for `tx_busy`=1, then go to TX_DRAIN.
  - TX_DRAIN [3]: wait for `tx_busy`=0.
    - Reset or LED command: pulse the matching ack, go to IDLE.
    - Poll command: go to WAIT_RSP with the timeout counter loaded to `TIMEOUT_CYCLES-1`.
  - WAIT_RSP [4]: on `rx_valid`, go to IDLE.
    - If `rx_data` ≠ 16'h0000: pulse `rsp_valid` and set `rsp_data`/`rsp_src`.
    - If the counter reaches 0 without `rx_valid`: increment `timeout_cnt` (saturates at 255) and go to IDLE.
- `rx_valid` outside WAIT_RSP is ignored.
- `enable` falling mid-transaction: the in-flight transaction completes normally; the FSM then stays in IDLE.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; `tx_cmd`=8'h00; `timeout_cnt`=0; poll target = keyboard; timer at reload.
- `tx_start` is high for exactly one cycle per transaction and is decoded from the state register.
- **Poll latency:** timer reaches 0 in cycle N → `poll_pending` visible in N+1 → `tx_start` high in N+2 (if IDLE and no higher-priority request).
- **Response latency:** `rsp_valid` is high the cycle after `rx_valid` is sampled. `rsp_data`/`rsp_src` hold until the next event.
- **Acks:** `led_ack`/`reset_ack` are high the cycle after `tx_busy` is sampled low in TX_DRAIN.
- **Simultaneous events:**
  - `rx_valid` in the same cycle the timeout reaches 0: the response wins; no timeout is counted.
  - `reset_req` and `led_req` together: reset is served first; LED is served in the next IDLE.
- `rst` mid-transaction: immediate return to IDLE with `tx_start` low; the external transmitter is not reset by this block.

## Configuration
- `NEXT_KMS_MOUSE_EN` defined: polls alternate KBD_POLL/MOUSE_POLL; `rsp_src` reflects the polled device.
- Not defined:
  - Only KBD_POLL is ever issued; MOUSE_POLL never appears on `tx_cmd`.
  - `rsp_src` is tied to 0.
  - The alternation register is removed.

## Test plan
- **Reset:** assert `rst` for 3 cycles → all outputs 0 and `state`=0.
- **Polling:** `POLL_CYCLES`=100, `enable`=1, no requests → `tx_start` pulses every 100 cycles.
  - With the macro: `tx_cmd` alternates 8'h10, 8'h11.
  - Without the macro: `tx_cmd` is always 8'h10.
- **Priority:** `reset_req` and `led_req` (`led_val`=2'b10) asserted together in IDLE → `tx_cmd`=8'hEF then `reset_ack`; next `tx_cmd`=8'h22 then `led_ack`.
- **Response filtering:**
  - After KBD_POLL, `rx_valid` with `rx_data`=16'h0042 → `rsp_valid` one cycle later, `rsp_data`=16'h0042, `rsp_src`=0.
  - With `rx_data`=16'h0000 → no `rsp_valid`.
- **Timeout:** `TIMEOUT_CYCLES`=10, no `rx_valid` → return to IDLE after 10 cycles in WAIT_RSP, `timeout_cnt`=1.
  - Force 300 timeouts → `timeout_cnt`=255.
- **Enable/race:** drop `enable` in TX_DRAIN → transaction completes and no further `tx_start`.
  - `rx_valid` coincident with the final timeout cycle → `rsp_valid` pulses and `timeout_cnt` is unchanged.
